// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall priority and the
// IF/ID pipeline register that feeds decode, including bubble insertion.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        ImemReady,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] r_pcf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;

  logic [31:0] w_pcplus4f;
  logic [31:0] w_pc_next;

  // Wraps naturally at 2^32; every PC source is word aligned.
  assign w_pcplus4f = r_pcf + 32'd4;

  always_comb begin
    w_pc_next = r_pcf;
    if (PCSrcE)
      w_pc_next = PCTargetE & ALIGN_MASK;
    else if (!StallF && ImemReady)
      w_pc_next = w_pcplus4f;
  end

  // ---- IF stage: program counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pcf <= RESET_PC & ALIGN_MASK;
    else
      r_pcf <= w_pc_next;
  end

  // ---- IF/ID boundary: flush beats stall, missing fetch becomes a bubble ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (FlushD || (!StallD && !ImemReady)) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!StallD) begin
      r_instr_d   <= InstrF;
      r_pc_d      <= r_pcf;
      r_pcplus4_d <= w_pcplus4f;
      r_valid_d   <= 1'b1;
    end
  end

  assign PCF      = r_pcf;
  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pcplus4_d;
  assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push hand-computed
// expectations, a monitor pops and compares after each edge or reset probe.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE, ImemReady;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4;
    logic        v;
  } exp_t;

  exp_t q[$];
  event sample_now;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReady(ImemReady),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  // Monitor: compare after every rising edge, or on an explicit async probe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or sample_now);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (PCF !== e.pcf || InstrD !== e.instr || PCD !== e.pcd ||
            PCPlus4D !== e.p4 || ValidD !== e.v) begin
          errors++;
          $display("FAIL %s: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, expected PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b",
                   e.name, PCF, InstrD, PCD, PCPlus4D, ValidD,
                   e.pcf, e.instr, e.pcd, e.p4, e.v);
        end
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [31:0] pcf,
                              input logic [31:0] ins, input logic [31:0] pcd,
                              input logic [31:0] p4, input logic v);
    exp_t e;
    e.name = nm; e.pcf = pcf; e.instr = ins; e.pcd = pcd; e.p4 = p4; e.v = v;
    return e;
  endfunction

  // Called at a falling edge: drive inputs, queue the post-edge expectation.
  task automatic step(input string nm, input logic sf, input logic sd,
                      input logic fd, input logic pcs, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] ins,
                      input logic [31:0] epcf, input logic [31:0] eins,
                      input logic [31:0] epcd, input logic [31:0] ep4,
                      input logic ev);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = pcs; PCTargetE = tgt;
    ImemReady = rdy; InstrF = ins;
    q.push_back(mk(nm, epcf, eins, epcd, ep4, ev));
    @(negedge clk);
  endtask

  task automatic probe(input string nm, input logic [31:0] epcf,
                       input logic [31:0] eins, input logic [31:0] epcd,
                       input logic [31:0] ep4, input logic ev);
    q.push_back(mk(nm, epcf, eins, epcd, ep4, ev));
    -> sample_now;
    #2;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    PCTargetE = '0; ImemReady = 1'b1; InstrF = 32'hDEAD_BEEF;
    #2;
    probe("reset_state", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step("run_A",  0,0,0,0,32'h0,1,32'hAAAA_0001, 32'h4, 32'hAAAA_0001, 32'h0, 32'h4, 1);
    step("run_B",  0,0,0,0,32'h0,1,32'hBBBB_0002, 32'h8, 32'hBBBB_0002, 32'h4, 32'h8, 1);
    step("run_C",  0,0,0,0,32'h0,1,32'hCCCC_0003, 32'hC, 32'hCCCC_0003, 32'h8, 32'hC, 1);
    step("stallF_1", 1,0,0,0,32'h0,1,32'hDDDD_0004, 32'hC, 32'hDDDD_0004, 32'hC, 32'h10, 1);
    step("stallF_2", 1,0,0,0,32'h0,1,32'hDDDD_0004, 32'hC, 32'hDDDD_0004, 32'hC, 32'h10, 1);
    step("redirect_over_stall", 1,0,0,1,32'h0000_0102,1,32'hEEEE_0005,
         32'h100, 32'hEEEE_0005, 32'hC, 32'h10, 1);
    step("flush_and_stallD", 0,1,1,0,32'h0,1,32'hFFFF_0006, 32'h104, NOP, 32'h0, 32'h0, 0);
    step("load_after_flush", 0,0,0,0,32'h0,1,32'h0000_1111, 32'h108, 32'h0000_1111, 32'h104, 32'h108, 1);
    step("stallD_hold", 0,1,0,0,32'h0,1,32'h0000_2222, 32'h10C, 32'h0000_1111, 32'h104, 32'h108, 1);
    step("flush_only", 0,0,1,0,32'h0,1,32'h0000_2323, 32'h110, NOP, 32'h0, 32'h0, 0);
    step("redirect_top", 0,0,0,1,32'hFFFF_FFFF,1,32'h0000_3333,
         32'hFFFF_FFFC, 32'h0000_3333, 32'h110, 32'h114, 1);
    step("pc_wrap", 0,0,0,0,32'h0,1,32'h0000_4444, 32'h0, 32'h0000_4444, 32'hFFFF_FFFC, 32'h0, 1);
    step("redirect_0x10", 0,0,0,1,32'h0000_0010,1,32'h0000_5555, 32'h10, 32'h0000_5555, 32'h0, 32'h4, 1);
    step("imem_wait_1", 0,0,0,0,32'h0,0,32'h0000_9999, 32'h10, NOP, 32'h0, 32'h0, 0);
    step("imem_wait_2", 0,0,0,0,32'h0,0,32'h0000_9999, 32'h10, NOP, 32'h0, 32'h0, 0);
    step("imem_ready", 0,0,0,0,32'h0,1,32'h0000_6666, 32'h14, 32'h0000_6666, 32'h10, 32'h14, 1);
    step("redirect_not_ready", 0,0,0,1,32'h0000_0040,0,32'h0000_9999, 32'h40, NOP, 32'h0, 32'h0, 0);
    step("stallF_at_40", 1,0,0,0,32'h0,1,32'h0000_7777, 32'h40, 32'h0000_7777, 32'h40, 32'h44, 1);

    // Async reset between edges while stalled and redirecting.
    StallF = 1; PCSrcE = 1; PCTargetE = 32'h0000_0200;
    #1;
    rst = 1'b1;
    probe("async_reset_mid_stall", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("first_after_reset", 0,0,0,0,32'h0,1,32'h0000_8888, 32'h4, 32'h0000_8888, 32'h0, 32'h4, 1);
    step("second_after_reset", 0,0,0,0,32'h0,1,32'h0000_8889, 32'h8, 32'h0000_8889, 32'h4, 32'h8, 1);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
